mem_refill_responder: RTL and testbench

- Memory-side responder for the cache-refill request/response interface driven by the instruction/data cache refill crossbar.
- Accepts val/rdy requests carrying rw, line address and tag into a small queue, then serves them in order.
- After a fixed access latency it performs a burst of line beats on a synchronous backing-RAM port.
- Reads return the request tag on mem_resp_val, one response per beat; writes produce no response.

---
 rtl/mem_refill_responder_pkg.sv | 13 +
 rtl/mem_req_queue.sv | 67 ++++++
 rtl/mem_refill_responder.sv | 151 +++++++++++++++
 tb/tb_mem_refill_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_refill_responder_pkg.sv
// Shared constants for the memory refill responder and its request queue.
`default_nettype none

package mem_refill_responder_pkg;

  localparam int MEM_ADDR_BITS = 26;
  localparam int MEM_TAG_BITS  = 8;
  localparam int REFILL_BEATS  = 4;
  localparam int MEM_LATENCY   = 4;

endpackage

`default_nettype wire

// File: rtl/mem_req_queue.sv
// Parameterised synchronous FIFO holding pending refill requests.
`default_nettype none

module mem_req_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = DEPTH[PW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_refill_responder.sv
// Memory-side refill responder: queues line requests, waits a fixed latency,
// then bursts line beats on the backing RAM and returns read response beats.
`default_nettype none

module mem_refill_responder
  import mem_refill_responder_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int TAG_BITS  = MEM_TAG_BITS,
  parameter int LATENCY   = MEM_LATENCY,
  parameter int BEATS     = REFILL_BEATS,
  parameter int QDEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               mem_req_val,
  output logic                               mem_req_rdy,
  input  logic                               mem_req_rw,
  input  logic [ADDR_BITS-1:0]               mem_req_addr,
  input  logic [TAG_BITS-1:0]                mem_req_tag,
  output logic                               mem_resp_val,
  output logic [TAG_BITS-1:0]                mem_resp_tag,
  output logic [$clog2(BEATS)-1:0]           mem_resp_beat,
  output logic                               ram_en,
  output logic                               ram_we,
  output logic [ADDR_BITS+$clog2(BEATS)-1:0] ram_addr
);

  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int REQ_W     = 1 + ADDR_BITS + TAG_BITS;
  localparam logic [BEAT_BITS-1:0] C_LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [3:0]           C_LAT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  typedef struct packed {
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [TAG_BITS-1:0]  tag;
  } req_t;

  state_e                           r_state;
  req_t                             r_cur;
  logic [3:0]                       r_lat;
  logic [BEAT_BITS-1:0]             r_beat;
  logic                             r_resp_val;
  logic [TAG_BITS-1:0]              r_resp_tag;
  logic [BEAT_BITS-1:0]             r_resp_beat;
  logic                             r_ram_en;
  logic                             r_ram_we;
  logic [ADDR_BITS+BEAT_BITS-1:0]   r_ram_addr;

  logic [REQ_W-1:0]                 w_req_in;
  req_t                             w_head;
  logic                             w_full;
  logic                             w_empty;
  logic                             w_pop;
  logic [BEAT_BITS-1:0]             w_next_beat;

  assign w_req_in    = {mem_req_rw, mem_req_addr, mem_req_tag};
  assign w_pop       = (r_state == ST_IDLE) & ~w_empty;
  assign w_next_beat = r_beat + BEAT_BITS'(1);
  assign mem_req_rdy = ~w_full;

  mem_req_queue #(
    .WIDTH (REQ_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (mem_req_val),
    .i_data  (w_req_in),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Outputs are registered and loaded one cycle ahead of the beat they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_lat       <= '0;
      r_beat      <= '0;
      r_resp_val  <= 1'b0;
      r_resp_tag  <= '0;
      r_resp_beat <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cur   <= w_head;
            r_lat   <= C_LAT_LOAD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_lat == 4'd0) begin
            r_beat      <= '0;
            r_state     <= ST_BURST;
            r_ram_en    <= 1'b1;
            r_ram_we    <= r_cur.rw;
            r_ram_addr  <= {r_cur.addr, BEAT_BITS'(0)};
            r_resp_val  <= ~r_cur.rw;
            r_resp_tag  <= r_cur.rw ? '0 : r_cur.tag;
            r_resp_beat <= '0;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        ST_BURST: begin
          if (r_beat == C_LAST_BEAT) begin
            r_beat      <= '0;
            r_state     <= ST_IDLE;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_resp_val  <= 1'b0;
            r_resp_tag  <= '0;
            r_resp_beat <= '0;
          end else begin
            r_beat      <= w_next_beat;
            r_ram_addr  <= {r_cur.addr, w_next_beat};
            r_resp_beat <= r_cur.rw ? '0 : w_next_beat;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_resp_val  = r_resp_val;
  assign mem_resp_tag  = r_resp_tag;
  assign mem_resp_beat = r_resp_beat;
  assign ram_en        = r_ram_en;
  assign ram_we        = r_ram_we;
  assign ram_addr      = r_ram_addr;

endmodule

`default_nettype wire

// File: tb/tb_mem_refill_responder.sv
// Directed self-checking bench for mem_refill_responder (LATENCY=4, BEATS=4, QDEPTH=4).
`default_nettype none

module tb_mem_refill_responder;

  localparam int AB = 26;
  localparam int TB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req_val = 1'b0;
  logic          mem_req_rdy;
  logic          mem_req_rw = 1'b0;
  logic [AB-1:0] mem_req_addr = '0;
  logic [TB-1:0] mem_req_tag = '0;
  logic          mem_resp_val;
  logic [TB-1:0] mem_resp_tag;
  logic [1:0]    mem_resp_beat;
  logic          ram_en;
  logic          ram_we;
  logic [AB+1:0] ram_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TB-1:0] q_tag[$];
  logic [1:0]    q_beat[$];

  mem_refill_responder #(
    .ADDR_BITS (AB),
    .TAG_BITS  (TB),
    .LATENCY   (4),
    .BEATS     (4),
    .QDEPTH    (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_val   (mem_req_val),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_tag  (mem_resp_tag),
    .mem_resp_beat (mem_resp_beat),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_resp_val) begin
      q_tag.push_back(mem_resp_tag);
      q_beat.push_back(mem_resp_beat);
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_tag.delete();
    q_beat.delete();
  endtask

  // Accept one request at the next edge (edge 0) and check cycles 1..10.
  task automatic single(input logic rw, input logic [AB-1:0] addr, input logic [TB-1:0] tag);
    mem_req_val = 1'b1; mem_req_rw = rw; mem_req_addr = addr; mem_req_tag = tag;
    tick();
    mem_req_val = 1'b0; mem_req_rw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      logic inb;
      int   b;
      tick();
      inb = (k >= 5) && (k <= 8);
      b   = k - 5;
      chk("ram_en", 32'(ram_en), 32'(inb));
      chk("ram_we", 32'(ram_we), 32'(inb & rw));
      chk("resp_val", 32'(mem_resp_val), 32'(inb & ~rw));
      if (inb) begin
        chk("ram_addr", 32'(ram_addr), (32'(addr) << 2) | 32'(b));
        if (!rw) begin
          chk("resp_tag", 32'(mem_resp_tag), 32'(tag));
          chk("resp_beat", 32'(mem_resp_beat), 32'(b));
        end
      end
    end
  endtask

  // Check that the log holds n requests, tags base+i, 4 ordered beats each.
  task automatic check_log(input string name, input int n, input logic [TB-1:0] base);
    chk({name, "_beats"}, 32'(q_tag.size()), 32'(4 * n));
    for (int i = 0; i < q_tag.size() && i < 4 * n; i++) begin
      chk({name, "_tag"}, 32'(q_tag[i]), 32'(base) + 32'(i / 4));
      chk({name, "_beat"}, 32'(q_beat[i]), 32'(i % 4));
    end
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_resp_val", 32'(mem_resp_val), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    #25;
    reset = 1'b1;
    tick();
    chk("rst_rdy", 32'(mem_req_rdy), 32'd1);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_resp_tag", 32'(mem_resp_tag), 32'd0);

    // Single read, then single write
    single(1'b0, 26'h123, 8'h05);
    single(1'b1, 26'h040, 8'h02);

    // Back-to-back reads: first burst cycles 5..8, idle 9, wait 10..13, second burst 14..17
    mem_req_val = 1'b1; mem_req_addr = 26'h010; mem_req_tag = 8'h01;
    tick();
    mem_req_addr = 26'h020; mem_req_tag = 8'h10;
    tick();
    mem_req_val = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      logic ina, inb2;
      tick();
      ina  = (k >= 5) && (k <= 8);
      inb2 = (k >= 14) && (k <= 17);
      chk("b2b_resp_val", 32'(mem_resp_val), 32'(ina | inb2));
      if (ina) begin
        chk("b2b_tag", 32'(mem_resp_tag), 32'h01);
        chk("b2b_beat", 32'(mem_resp_beat), 32'(k - 5));
      end
      if (inb2) begin
        chk("b2b_tag", 32'(mem_resp_tag), 32'h10);
        chk("b2b_beat", 32'(mem_resp_beat), 32'(k - 14));
        chk("b2b_addr", 32'(ram_addr), 32'h80 | 32'(k - 14));
      end
    end

    // Full queue: tags 0x20..0x24 accepted at edges 0..4; 0x2F offered while full
    clear_log();
    mem_req_val = 1'b1; mem_req_addr = 26'h200; mem_req_tag = 8'h20;
    for (int k = 0; k <= 10; k++) begin
      tick();
      chk("fq_rdy", 32'(mem_req_rdy), 32'(!((k >= 4) && (k <= 9))));
      mem_req_tag = (k < 4) ? 8'(8'h21 + k) : 8'h2F;
    end
    mem_req_val = 1'b0;
    repeat (60) tick();
    check_log("fq", 5, 8'h20);

    // Reset mid-burst: beat 1 of tag 0x33, with 0x34 queued behind it
    clear_log();
    mem_req_val = 1'b1; mem_req_addr = 26'h300; mem_req_tag = 8'h33;
    tick();
    mem_req_tag = 8'h34;
    tick();
    mem_req_val = 1'b0;
    repeat (5) tick();
    chk("mb_resp_val", 32'(mem_resp_val), 32'd1);
    chk("mb_beat", 32'(mem_resp_beat), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mb_async_resp_val", 32'(mem_resp_val), 32'd0);
    chk("mb_async_ram_en", 32'(ram_en), 32'd0);
    chk("mb_async_ram_we", 32'(ram_we), 32'd0);
    chk("mb_async_ram_addr", 32'(ram_addr), 32'd0);
    #2;
    reset = 1'b1;
    clear_log();
    repeat (30) tick();
    chk("mb_no_resp", 32'(q_tag.size()), 32'd0);
    chk("mb_rdy", 32'(mem_req_rdy), 32'd1);

    // Pointer wrap: 10 sequential reads
    clear_log();
    for (int i = 0; i < 10; i++) begin
      logic acc;
      acc = 1'b0;
      mem_req_val = 1'b1; mem_req_addr = 26'(i); mem_req_tag = 8'(8'h40 + i);
      for (int c = 0; c < 100 && !acc; c++) begin
        acc = mem_req_rdy;
        tick();
      end
      if (!acc) chk("wrap_accept_timeout", 32'd0, 32'd1);
    end
    mem_req_val = 1'b0;
    repeat (150) tick();
    check_log("wrap", 10, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
